// File: rtl/fifo_word_unpacker.sv
// Drains WIDTH-bit words from a registered-read FIFO and emits them as OUT_WIDTH-bit
// beats on a valid/ready stream, lane 0 first, with a one-word prefetch to hide read latency.
module fifo_word_unpacker #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    output logic                 fifo_read_en,
    input  logic [WIDTH-1:0]     fifo_read_data,
    output logic                 m_valid,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 busy
);
    localparam int LANES = WIDTH / OUT_WIDTH;
    localparam int LW    = $clog2(LANES);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    logic [WIDTH-1:0] word_q, word_d;
    logic             word_v_q, word_v_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [WIDTH-1:0] pf_q, pf_d;
    logic             pf_v_q, pf_v_d;
    logic             pend_q, pend_d;

    logic [1:0] occupancy_s;
    logic       hs_s;
    logic       last_s;
    logic       word_free_s;
    logic       load_pf_s;
    logic       load_rd_s;

    // Pop request: at most two words held or in flight, never pop an empty FIFO.
    always_comb begin
        occupancy_s  = {1'b0, word_v_q} + {1'b0, pf_v_q} + {1'b0, pend_q};
        fifo_read_en = !reset && !fifo_empty && (occupancy_s < 2'd2);
    end

    // Next-state for the word register, lane counter, prefetch slot and in-flight flag.
    always_comb begin
        hs_s        = word_v_q && m_ready;
        last_s      = (lane_q == LAST_LANE);
        word_free_s = !word_v_q || (hs_s && last_s);
        load_pf_s   = word_free_s && pf_v_q;
        load_rd_s   = word_free_s && !pf_v_q && pend_q;

        word_d   = word_q;
        word_v_d = word_v_q;
        lane_d   = lane_q;
        pf_d     = pf_q;
        pf_v_d   = pf_v_q;
        pend_d   = fifo_read_en;

        // The prefetched word is older than returning data, so it wins the word register.
        if (load_pf_s) begin
            word_d   = pf_q;
            word_v_d = 1'b1;
            lane_d   = '0;
        end else if (load_rd_s) begin
            word_d   = fifo_read_data;
            word_v_d = 1'b1;
            lane_d   = '0;
        end else if (hs_s) begin
            if (last_s) begin
                word_v_d = 1'b0;
                lane_d   = '0;
            end else begin
                lane_d = lane_q + LW'(1);
            end
        end else begin
            word_v_d = word_v_q;
        end

        if (pend_q && !load_rd_s) begin
            pf_d   = fifo_read_data;
            pf_v_d = 1'b1;
        end else if (load_pf_s) begin
            pf_v_d = 1'b0;
        end else begin
            pf_v_d = pf_v_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q   <= '0;
            word_v_q <= 1'b0;
            lane_q   <= '0;
            pf_q     <= '0;
            pf_v_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            word_q   <= word_d;
            word_v_q <= word_v_d;
            lane_q   <= lane_d;
            pf_q     <= pf_d;
            pf_v_q   <= pf_v_d;
            pend_q   <= pend_d;
        end
    end

    assign m_valid = word_v_q;
    assign m_data  = word_q[lane_q*OUT_WIDTH +: OUT_WIDTH];
    assign m_last  = last_s;
    assign busy    = word_v_q || pf_v_q || pend_q;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Bench for fifo_word_unpacker: a queue-based FIFO model with registered read data
// feeds the DUT, and a beat scoreboard built from pushed words checks the output stream.
module tb_fifo_word_unpacker;
    localparam int WIDTH     = 32;
    localparam int OUT_WIDTH = 8;
    localparam int LANES     = WIDTH / OUT_WIDTH;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 fifo_empty;
    logic                 fifo_read_en;
    logic [WIDTH-1:0]     fifo_read_data;
    logic                 m_valid;
    logic [OUT_WIDTH-1:0] m_data;
    logic                 m_last;
    logic                 m_ready;
    logic                 busy;

    always #5 clk = ~clk;

    fifo_word_unpacker #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_empty     (fifo_empty),
        .fifo_read_en   (fifo_read_en),
        .fifo_read_data (fifo_read_data),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_last         (m_last),
        .m_ready        (m_ready),
        .busy           (busy)
    );

    logic [WIDTH-1:0] fq[$];
    logic [8:0]       exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int pops     = 0;
    int done     = 0;

    logic       s_valid, s_last, s_busy, s_re, s_empty, s_ready;
    logic [7:0] s_data;
    int         s_occ;

    task automatic push_word(input logic [WIDTH-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
        for (int i = 0; i < LANES; i++)
            exp_q.push_back({(i == LANES - 1), w[i*OUT_WIDTH +: OUT_WIDTH]});
    endtask

    // Sample the DUT mid-cycle, then advance the FIFO model past the next rising edge.
    task automatic tick();
        @(negedge clk);
        s_valid = m_valid;  s_data = m_data;  s_last = m_last;  s_busy = busy;
        s_re = fifo_read_en; s_empty = fifo_empty; s_ready = m_ready;
        s_occ = pops - done;
        @(posedge clk);
        #1;
        if (reset) begin
            fq.delete();
            exp_q.delete();
            pops = 0;
            done = 0;
            fifo_empty = 1'b1;
        end else begin
            if (s_re) begin
                pops++;
                if (fq.size() > 0) fifo_read_data = fq.pop_front();
            end
            if (s_valid && s_ready && s_last) done++;
            fifo_empty = (fq.size() == 0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; m_ready = 1'b1;
        push_word(32'hCAFEF00D);
        tick();
        n_checks++;
        if (s_re !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", s_re); end
        reset = 1'b0;
        tick();
        n_checks++;
        if (s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", s_valid); end
        n_checks++;
        if (s_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", s_last); end
        n_checks++;
        if (s_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", s_data); end
        n_checks++;
        if (s_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", s_busy); end
        n_checks++;
        if (s_re !== 1'b0) begin n_fail++; $display("FAIL reset_idle_rd_en: got %b expected 0", s_re); end
    endtask

    task automatic test_single_word();
        int pop_cnt = 0, pop_at = -1, first = -1, lastc = -1, nb = 0, last_cnt = 0;
        logic [8:0] exp_b;
        m_ready = 1'b1;
        push_word(32'h44332211);
        for (int c = 0; c < 12; c++) begin
            tick();
            if (s_re) begin pop_cnt++; pop_at = c; end
            if (nb == LANES && c == lastc + 1) begin
                n_checks++;
                if (s_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b expected 0", s_busy); end
            end
            if (s_valid && s_ready) begin
                exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                n_checks++;
                if ({s_last, s_data} !== exp_b) begin
                    n_fail++; $display("FAIL single_beat: got %h expected %h", {s_last, s_data}, exp_b);
                end
                if (first < 0) first = c;
                lastc = c; nb++;
                if (s_last) last_cnt++;
            end
        end
        n_checks++;
        if (pop_cnt !== 1) begin n_fail++; $display("FAIL single_pops: got %0d expected 1", pop_cnt); end
        n_checks++;
        if (first !== pop_at + 2) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", first, pop_at + 2); end
        n_checks++;
        if (nb !== 4 || lastc - first !== 3) begin
            n_fail++; $display("FAIL single_beats: got %0d beats over %0d cycles expected 4 over 3", nb, lastc - first);
        end
        n_checks++;
        if (last_cnt !== 1) begin n_fail++; $display("FAIL single_last_cnt: got %0d expected 1", last_cnt); end
    endtask

    task automatic test_three_stream();
        int first = -1, lastc = -1, nb = 0;
        logic [8:0] exp_b;
        m_ready = 1'b1;
        push_word(32'h03020100);
        push_word(32'h07060504);
        push_word(32'h0B0A0908);
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if (s_occ > 2 || (s_re && s_empty)) begin
                n_fail++; $display("FAIL stream_occ: got occ %0d re %b empty %b expected occ<=2 no underflow", s_occ, s_re, s_empty);
            end
            if (s_valid && s_ready) begin
                exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                n_checks++;
                if ({s_last, s_data} !== exp_b || s_data !== 8'(nb)) begin
                    n_fail++; $display("FAIL stream_beat: got %h expected %h", {s_last, s_data}, exp_b);
                end
                if (first < 0) first = c;
                lastc = c; nb++;
            end
        end
        n_checks++;
        if (nb !== 12 || lastc - first !== 11) begin
            n_fail++; $display("FAIL stream_gapless: got %0d beats over %0d cycles expected 12 over 11", nb, lastc - first);
        end
    endtask

    task automatic test_stall();
        int stall_pops = 0, pop_cnt = 0, third_pop = -1, w0_done = -1, nb = 0;
        logic [8:0] exp_b;
        m_ready = 1'b0;
        push_word(32'h03020100);
        push_word(32'h07060504);
        push_word(32'h0B0A0908);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (s_re) stall_pops++;
            if (s_valid) begin
                n_checks++;
                if (s_data !== 8'h00 || s_last !== 1'b0) begin
                    n_fail++; $display("FAIL stall_hold: got %h last %b expected 00 last 0", s_data, s_last);
                end
            end
        end
        n_checks++;
        if (stall_pops !== 2) begin n_fail++; $display("FAIL stall_pops: got %0d expected 2", stall_pops); end
        n_checks++;
        if (s_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b expected 1", s_valid); end
        pop_cnt = stall_pops;
        m_ready = 1'b1;
        for (int c = 10; c < 32; c++) begin
            tick();
            if (s_re) begin pop_cnt++; if (pop_cnt == 3) third_pop = c; end
            if (s_valid && s_ready) begin
                exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                n_checks++;
                if ({s_last, s_data} !== exp_b) begin
                    n_fail++; $display("FAIL stall_beat: got %h expected %h", {s_last, s_data}, exp_b);
                end
                if (s_last && w0_done < 0) w0_done = c;
                nb++;
            end
        end
        n_checks++;
        if (third_pop <= w0_done) begin
            n_fail++; $display("FAIL stall_third_pop: got cycle %0d expected after %0d", third_pop, w0_done);
        end
        n_checks++;
        if (nb !== 12) begin n_fail++; $display("FAIL stall_count: got %0d expected 12", nb); end
    endtask

    task automatic test_toggle();
        logic       p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
        logic [7:0] p_data = 8'h00;
        logic [8:0] exp_b;
        m_ready = 1'b1;
        for (int c = 0; c < 160; c++) begin
            if (c < 80 && fq.size() < 4 && $urandom_range(0, 3) == 0) push_word($urandom);
            tick();
            n_checks++;
            if (s_occ > 2 || (s_re && s_empty)) begin
                n_fail++; $display("FAIL toggle_occ: got occ %0d re %b empty %b expected occ<=2 no underflow", s_occ, s_re, s_empty);
            end
            n_checks++;
            if (s_busy !== (s_occ > 0)) begin
                n_fail++; $display("FAIL toggle_busy: got %b expected %b", s_busy, (s_occ > 0));
            end
            if (p_valid && !p_ready) begin
                n_checks++;
                if (s_valid !== 1'b1 || s_data !== p_data || s_last !== p_last) begin
                    n_fail++; $display("FAIL toggle_stable: got %b %h %b expected 1 %h %b", s_valid, s_data, s_last, p_data, p_last);
                end
            end
            if (s_valid && s_ready) begin
                exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                n_checks++;
                if ({s_last, s_data} !== exp_b) begin
                    n_fail++; $display("FAIL toggle_beat: got %h expected %h", {s_last, s_data}, exp_b);
                end
            end
            p_valid = s_valid; p_ready = s_ready; p_data = s_data; p_last = s_last;
            if (c < 16) m_ready = c[0];
            else if (c < 90) m_ready = 1'($urandom_range(0, 1));
            else m_ready = 1'b1;
        end
        n_checks++;
        if (exp_q.size() !== 0 || s_busy !== 1'b0) begin
            n_fail++; $display("FAIL toggle_drain: got %0d beats left busy %b expected 0 busy 0", exp_q.size(), s_busy);
        end
    endtask

    task automatic test_empty();
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if (s_re !== 1'b0 || s_valid !== 1'b0 || s_busy !== 1'b0) begin
                n_fail++; $display("FAIL empty_idle: got re %b valid %b busy %b expected 0 0 0", s_re, s_valid, s_busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic       found = 1'b0;
        int         nb = 0;
        logic [8:0] exp_b;
        logic [7:0] want;
        logic [31:0] new_word = 32'hDDCCBBAA;
        m_ready = 1'b1;
        push_word(32'h44332211);
        push_word(32'h88776655);
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (s_valid && s_ready) begin
                exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                n_checks++;
                if ({s_last, s_data} !== exp_b) begin
                    n_fail++; $display("FAIL mid_beat: got %h expected %h", {s_last, s_data}, exp_b);
                end
                if (s_data == 8'h22) begin
                    found = 1'b1;
                    n_checks++;
                    if (s_occ !== 2) begin n_fail++; $display("FAIL mid_occ: got %0d expected 2", s_occ); end
                end
            end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL mid_timeout: got no 22 beat expected one within 20 cycles"); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_data !== 8'h00 || s_last !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got valid %b busy %b data %h last %b expected 0 0 00 0", s_valid, s_busy, s_data, s_last);
        end
        push_word(new_word);
        for (int c = 0; c < 12; c++) begin
            tick();
            if (s_valid && s_ready) begin
                want = (nb < 4) ? new_word[nb*8 +: 8] : 8'h00;
                exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                n_checks++;
                if ({s_last, s_data} !== exp_b || s_data !== want) begin
                    n_fail++; $display("FAIL mid_new_beat: got %h expected %h", s_data, want);
                end
                nb++;
            end
        end
        n_checks++;
        if (nb !== 4) begin n_fail++; $display("FAIL mid_new_count: got %0d expected 4", nb); end
    endtask

    initial begin
        reset = 1'b1;
        m_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_read_data = '0;
        test_reset();
        test_single_word();
        test_three_stream();
        test_stall();
        test_toggle();
        test_empty();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
